// File: rtl/alu_exec_unit_if.sv
// alu_exec_unit_if: RS dispatch bus into the ALU plus the registered CDB result bus out of it
interface alu_exec_unit_if #(
  parameter int DATA_W    = 32,
  parameter int ROB_IDX_W = 5,
  parameter int OP_W      = 6
);
  logic                 rs_to_alu_ready;
  logic [OP_W-1:0]      rs_to_alu_op;
  logic [DATA_W-1:0]    rs_to_alu_rs1;
  logic [DATA_W-1:0]    rs_to_alu_rs2;
  logic [ROB_IDX_W-1:0] rs_to_alu_rob_index;
  logic [DATA_W-1:0]    rs_to_alu_PC;
  logic [DATA_W-1:0]    rs_to_alu_imm;
  logic                 alu_ready;
  logic [DATA_W-1:0]    alu_result;
  logic [ROB_IDX_W-1:0] alu_rob_index;
  logic                 alu_jump;
  logic [DATA_W-1:0]    alu_target_PC;
  modport master (
    output rs_to_alu_ready, rs_to_alu_op, rs_to_alu_rs1, rs_to_alu_rs2,
           rs_to_alu_rob_index, rs_to_alu_PC, rs_to_alu_imm,
    input  alu_ready, alu_result, alu_rob_index, alu_jump, alu_target_PC
  );
  modport slave (
    input  rs_to_alu_ready, rs_to_alu_op, rs_to_alu_rs1, rs_to_alu_rs2,
           rs_to_alu_rob_index, rs_to_alu_PC, rs_to_alu_imm,
    output alu_ready, alu_result, alu_rob_index, alu_jump, alu_target_PC
  );
endinterface

// File: rtl/alu_exec_unit.sv
// alu_exec_unit: RV32I integer/branch/jump execute stage with one-cycle registered CDB result (optional ALU_BRANCH_STAT_EN branch counters)
module alu_exec_unit #(
  parameter int DATA_W    = 32,
  parameter int ROB_IDX_W = 5,
  parameter int OP_W      = 6
) (
  input  logic          clk_in,
  input  logic          rst_n_in,
  input  logic          rdy_in,
  input  logic          clr_in,
  alu_exec_unit_if.slave bus
`ifdef ALU_BRANCH_STAT_EN
  ,
  output logic [31:0]   stat_branch_cnt,
  output logic [31:0]   stat_taken_cnt
`endif
);
  localparam logic [OP_W-1:0] OP_LUI   = OP_W'(1);
  localparam logic [OP_W-1:0] OP_AUIPC = OP_W'(2);
  localparam logic [OP_W-1:0] OP_JAL   = OP_W'(3);
  localparam logic [OP_W-1:0] OP_JALR  = OP_W'(4);
  localparam logic [OP_W-1:0] OP_BEQ   = OP_W'(5);
  localparam logic [OP_W-1:0] OP_BNE   = OP_W'(6);
  localparam logic [OP_W-1:0] OP_BLT   = OP_W'(7);
  localparam logic [OP_W-1:0] OP_BGE   = OP_W'(8);
  localparam logic [OP_W-1:0] OP_BLTU  = OP_W'(9);
  localparam logic [OP_W-1:0] OP_BGEU  = OP_W'(10);
  localparam logic [OP_W-1:0] OP_ADDI  = OP_W'(11);
  localparam logic [OP_W-1:0] OP_SLTI  = OP_W'(12);
  localparam logic [OP_W-1:0] OP_SLTIU = OP_W'(13);
  localparam logic [OP_W-1:0] OP_XORI  = OP_W'(14);
  localparam logic [OP_W-1:0] OP_ORI   = OP_W'(15);
  localparam logic [OP_W-1:0] OP_ANDI  = OP_W'(16);
  localparam logic [OP_W-1:0] OP_SLLI  = OP_W'(17);
  localparam logic [OP_W-1:0] OP_SRLI  = OP_W'(18);
  localparam logic [OP_W-1:0] OP_SRAI  = OP_W'(19);
  localparam logic [OP_W-1:0] OP_ADD   = OP_W'(20);
  localparam logic [OP_W-1:0] OP_SUB   = OP_W'(21);
  localparam logic [OP_W-1:0] OP_SLL   = OP_W'(22);
  localparam logic [OP_W-1:0] OP_SLT   = OP_W'(23);
  localparam logic [OP_W-1:0] OP_SLTU  = OP_W'(24);
  localparam logic [OP_W-1:0] OP_XOR   = OP_W'(25);
  localparam logic [OP_W-1:0] OP_SRL   = OP_W'(26);
  localparam logic [OP_W-1:0] OP_SRA   = OP_W'(27);
  localparam logic [OP_W-1:0] OP_OR    = OP_W'(28);
  localparam logic [OP_W-1:0] OP_AND   = OP_W'(29);
  logic [DATA_W-1:0] rs1, rs2, imm, pc, pc4, pc_imm, res, tgt;
  logic [4:0]        sh_i, sh_r;
  logic              jmp, br, tk, accept;
  assign rs1    = bus.rs_to_alu_rs1;
  assign rs2    = bus.rs_to_alu_rs2;
  assign imm    = bus.rs_to_alu_imm;
  assign pc     = bus.rs_to_alu_PC;
  assign pc4    = pc + DATA_W'(4);
  assign pc_imm = pc + imm;
  assign sh_i   = imm[4:0];
  assign sh_r   = rs2[4:0];
  assign accept = rdy_in && !clr_in && bus.rs_to_alu_ready;
  // decode and compute result, taken flag and actual next PC for the presented op
  always_comb begin
    res = '0;
    jmp = 1'b0;
    tgt = pc4;
    br  = 1'b0;
    tk  = 1'b0;
    case (bus.rs_to_alu_op)
      OP_LUI:   res = imm;
      OP_AUIPC: res = pc_imm;
      OP_JAL:   begin res = pc4; jmp = 1'b1; tgt = pc_imm; end
      OP_JALR:  begin res = pc4; jmp = 1'b1; tgt = (rs1 + imm) & ~DATA_W'(1); end
      OP_BEQ:   begin br = 1'b1; tk = rs1 == rs2; end
      OP_BNE:   begin br = 1'b1; tk = rs1 != rs2; end
      OP_BLT:   begin br = 1'b1; tk = $signed(rs1) < $signed(rs2); end
      OP_BGE:   begin br = 1'b1; tk = $signed(rs1) >= $signed(rs2); end
      OP_BLTU:  begin br = 1'b1; tk = rs1 < rs2; end
      OP_BGEU:  begin br = 1'b1; tk = rs1 >= rs2; end
      OP_ADDI:  res = rs1 + imm;
      OP_SLTI:  res = DATA_W'($signed(rs1) < $signed(imm));
      OP_SLTIU: res = DATA_W'(rs1 < imm);
      OP_XORI:  res = rs1 ^ imm;
      OP_ORI:   res = rs1 | imm;
      OP_ANDI:  res = rs1 & imm;
      OP_SLLI:  res = rs1 << sh_i;
      OP_SRLI:  res = rs1 >> sh_i;
      OP_SRAI:  res = $signed(rs1) >>> sh_i;
      OP_ADD:   res = rs1 + rs2;
      OP_SUB:   res = rs1 - rs2;
      OP_SLL:   res = rs1 << sh_r;
      OP_SLT:   res = DATA_W'($signed(rs1) < $signed(rs2));
      OP_SLTU:  res = DATA_W'(rs1 < rs2);
      OP_XOR:   res = rs1 ^ rs2;
      OP_SRL:   res = rs1 >> sh_r;
      OP_SRA:   res = $signed(rs1) >>> sh_r;
      OP_OR:    res = rs1 | rs2;
      OP_AND:   res = rs1 & rs2;
      default:  res = '0;
    endcase
    if (br) begin
      res = DATA_W'(tk);
      jmp = tk;
      tgt = tk ? pc_imm : pc4;
    end
  end
  // register one result per cycle onto the CDB; flush drops the pulse, !rdy freezes everything
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      bus.alu_ready     <= 1'b0;
      bus.alu_result    <= '0;
      bus.alu_rob_index <= '0;
      bus.alu_jump      <= 1'b0;
      bus.alu_target_PC <= '0;
    end else if (clr_in) begin
      bus.alu_ready <= 1'b0;
    end else if (rdy_in) begin
      bus.alu_ready <= bus.rs_to_alu_ready;
      if (bus.rs_to_alu_ready) begin
        bus.alu_result    <= res;
        bus.alu_rob_index <= bus.rs_to_alu_rob_index;
        bus.alu_jump      <= jmp;
        bus.alu_target_PC <= tgt;
      end
    end
  end
`ifdef ALU_BRANCH_STAT_EN
  // saturating counts of accepted branches and of the taken ones; only reset clears them
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      stat_branch_cnt <= '0;
      stat_taken_cnt  <= '0;
    end else if (accept && br) begin
      if (stat_branch_cnt != '1) stat_branch_cnt <= stat_branch_cnt + 32'd1;
      if (tk && stat_taken_cnt != '1) stat_taken_cnt <= stat_taken_cnt + 32'd1;
    end
  end
`else
  logic unused_accept;
  assign unused_accept = accept;
`endif
endmodule
